// File: rtl/pipe_front_regs_pkg.sv
// Shared CPU front-end definitions: fetch/decode constants, next-PC select,
// and packed pipeline-register payloads.
package pipe_front_regs_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_ALU    = 2'b10,
        PC_RSVD   = 2'b11
    } pcsrc_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic        branch;
        logic        jump;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } idex_t;

    localparam int IFID_W = $bits(ifid_t);
    localparam int IDEX_W = $bits(idex_t);

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/pipe_front_regs_pipe_reg.sv
// Generic pipeline register: reset and clear both load RST_VAL, clear beats hold.
// One cycle latency; i_en=0 holds the current contents.
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_front_regs.sv
// Fetch PC, IF/ID and ID/EX registers with stall/flush control and hazard counters.
// Redirects beat StallF; FlushD beats StallD; all outputs come straight from flops.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC  = pipe_front_regs_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipe_front_regs_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        FlushE,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] InstrF,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        ResultSrcD,
    input  logic        BranchD,
    input  logic        JumpD,
    input  logic [4:0]  Ra1D,
    input  logic [4:0]  Ra2D,
    input  logic [4:0]  RdD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] ImmExtD,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        ResultSrcE,
    output logic        BranchE,
    output logic        JumpE,
    output logic [4:0]  Ra1E,
    output logic [4:0]  Ra2E,
    output logic [4:0]  RdE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic        ValidE,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
);

    import pipe_front_regs_pkg::*;

    localparam ifid_t IFID_RST = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

    logic [31:0] r_pcf;
    logic [31:0] w_pcf_plus4;
    logic [31:0] w_pc_next;
    ifid_t       w_ifid_d;
    ifid_t       w_ifid_q;
    idex_t       w_idex_d;
    idex_t       w_idex_q;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    assign w_pcf_plus4 = r_pcf + 32'd4;

    // The reserved encoding follows the branch/JAL target path.
    always_comb begin
        w_pc_next = w_pcf_plus4;
        case (pcsrc_e'(PCSrcE))
            PC_PLUS4:  w_pc_next = StallF ? r_pcf : w_pcf_plus4;
            PC_TARGET: w_pc_next = PCTargetE;
            PC_ALU:    w_pc_next = ALUResultE;
            PC_RSVD:   w_pc_next = PCTargetE;
            default:   w_pc_next = w_pcf_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcf       <= RESET_PC;
            r_stall_cnt <= 16'h0;
            r_flush_cnt <= 16'h0;
        end else begin
            r_pcf       <= w_pc_next;
            r_stall_cnt <= sat_inc(r_stall_cnt, StallD);
            r_flush_cnt <= sat_inc(r_flush_cnt, FlushD | FlushE);
        end
    end

    assign w_ifid_d = '{instr: InstrF, pc: r_pcf, pc_plus4: w_pcf_plus4, valid: 1'b1};

    pipe_reg #(
        .W       (IFID_W),
        .RST_VAL (IFID_RST)
    ) u_ifid (
        .clk   (clk),
        .rst   (rst),
        .i_en  (~StallD),
        .i_clr (FlushD),
        .i_d   (w_ifid_d),
        .o_q   (w_ifid_q)
    );

    assign w_idex_d = '{
        reg_write:  RegWriteD,
        mem_write:  MemWriteD,
        result_src: ResultSrcD,
        branch:     BranchD,
        jump:       JumpD,
        ra1:        Ra1D,
        ra2:        Ra2D,
        rd:         RdD,
        rd1:        RD1D,
        rd2:        RD2D,
        imm_ext:    ImmExtD,
        pc:         w_ifid_q.pc,
        pc_plus4:   w_ifid_q.pc_plus4,
        valid:      w_ifid_q.valid
    };

    // Execute never stalls; a flush inserts an all-zero bubble.
    pipe_reg #(
        .W       (IDEX_W),
        .RST_VAL ('0)
    ) u_idex (
        .clk   (clk),
        .rst   (rst),
        .i_en  (1'b1),
        .i_clr (FlushE),
        .i_d   (w_idex_d),
        .o_q   (w_idex_q)
    );

    assign PCF        = r_pcf;
    assign InstrD     = w_ifid_q.instr;
    assign PCD        = w_ifid_q.pc;
    assign PCPlus4D   = w_ifid_q.pc_plus4;
    assign ValidD     = w_ifid_q.valid;
    assign RegWriteE  = w_idex_q.reg_write;
    assign MemWriteE  = w_idex_q.mem_write;
    assign ResultSrcE = w_idex_q.result_src;
    assign BranchE    = w_idex_q.branch;
    assign JumpE      = w_idex_q.jump;
    assign Ra1E       = w_idex_q.ra1;
    assign Ra2E       = w_idex_q.ra2;
    assign RdE        = w_idex_q.rd;
    assign RD1E       = w_idex_q.rd1;
    assign RD2E       = w_idex_q.rd2;
    assign ImmExtE    = w_idex_q.imm_ext;
    assign PCE        = w_idex_q.pc;
    assign PCPlus4E   = w_idex_q.pc_plus4;
    assign ValidE     = w_idex_q.valid;
    assign StallCnt   = r_stall_cnt;
    assign FlushCnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Randomized scoreboard bench for pipe_front_regs with directed hazard scenarios.
module tb_pipe_front_regs;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, StallF, StallD, FlushD, FlushE;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE, ALUResultE, InstrF;
    logic        RegWriteD, MemWriteD, ResultSrcD, BranchD, JumpD;
    logic [4:0]  Ra1D, Ra2D, RdD;
    logic [31:0] RD1D, RD2D, ImmExtD;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE;
    logic [4:0]  Ra1E, Ra2E, RdE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic        ValidE;
    logic [15:0] StallCnt, FlushCnt;

    typedef struct packed {
        logic        rw, mw, rs, br, jp;
        logic [4:0]  ra1, ra2, rd;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic        v;
    } ex_t;

    typedef struct packed {
        logic [31:0] pcf, instr_d, pc_d, pc4_d;
        logic        v_d;
        ex_t         e;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] last_fetched;

    always #5 clk = ~clk;

    pipe_front_regs #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE), .InstrF(InstrF),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .BranchD(BranchD),
        .JumpD(JumpD), .Ra1D(Ra1D), .Ra2D(Ra2D), .RdD(RdD), .RD1D(RD1D), .RD2D(RD2D),
        .ImmExtD(ImmExtD), .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .Ra1E(Ra1E), .Ra2E(Ra2E), .RdE(RdE), .RD1E(RD1E),
        .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .ValidE(ValidE),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: one pipeline step computed from the hazard rules, queued
    // for the monitor, then the clock edge is taken.
    task automatic tick();
        exp_t n;
        longint unsigned cnt;
        n = m;
        if (rst) begin
            n = '0;
            n.pcf     = RST_PC;
            n.instr_d = NOP;
        end else begin
            if (PCSrcE == 2'b10)      n.pcf = ALUResultE;
            else if (PCSrcE != 2'b00) n.pcf = PCTargetE;
            else if (!StallF)         n.pcf = 32'((64'(m.pcf) + 64'd4) % 64'h1_0000_0000);
            if (FlushE) n.e = '0;
            else n.e = '{rw: RegWriteD, mw: MemWriteD, rs: ResultSrcD, br: BranchD, jp: JumpD,
                         ra1: Ra1D, ra2: Ra2D, rd: RdD, rd1: RD1D, rd2: RD2D, imm: ImmExtD,
                         pc: m.pc_d, pc4: m.pc4_d, v: m.v_d};
            if (FlushD) begin
                n.instr_d = NOP; n.pc_d = 0; n.pc4_d = 0; n.v_d = 1'b0;
            end else if (!StallD) begin
                n.instr_d = InstrF; n.pc_d = m.pcf; n.pc4_d = m.pcf + 32'd4; n.v_d = 1'b1;
                last_fetched = InstrF;
            end
            cnt  = longint'(m.sc) + (StallD ? 1 : 0);
            n.sc = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
            cnt  = longint'(m.fc) + ((FlushD || FlushE) ? 1 : 0);
            n.fc = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
        end
        m = n;
        sb.push_back(n);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        ex_t  got_e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got_e = '{rw: RegWriteE, mw: MemWriteE, rs: ResultSrcE, br: BranchE, jp: JumpE,
                      ra1: Ra1E, ra2: Ra2E, rd: RdE, rd1: RD1E, rd2: RD2E, imm: ImmExtE,
                      pc: PCE, pc4: PCPlus4E, v: ValidE};
            chk("sb_PCF", PCF, e.pcf);
            chk("sb_InstrD", InstrD, e.instr_d);
            chk("sb_PCD", PCD, e.pc_d);
            chk("sb_PCPlus4D", PCPlus4D, e.pc4_d);
            chk("sb_ValidD", 32'(ValidD), 32'(e.v_d));
            n_tests++;
            if (got_e !== e.e) begin
                n_fail++;
                $display("FAIL sb_IDEX got=%h want=%h at %0t", got_e, e.e, $time);
            end
            chk("sb_StallCnt", 32'(StallCnt), 32'(e.sc));
            chk("sb_FlushCnt", 32'(FlushCnt), 32'(e.fc));
        end
    end

    task automatic rand_data();
        InstrF = $urandom; PCTargetE = $urandom & 32'hFFFF_FFFC; ALUResultE = $urandom & 32'hFFFF_FFFC;
        RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); ResultSrcD = 1'($urandom);
        BranchD = 1'($urandom); JumpD = 1'($urandom);
        Ra1D = 5'($urandom); Ra2D = 5'($urandom); RdD = 5'($urandom);
        RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
    endtask

    task automatic quiet();
        rand_data();
        rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0; PCSrcE = 2'b00;
    endtask

    initial begin
        logic [31:0] held;
        quiet();
        // Reset with a pending redirect: reset must win.
        rst = 1'b1; PCSrcE = 2'b01; PCTargetE = 32'h100;
        tick(); tick();
        chk("rst_PCF", PCF, 32'h0);
        chk("rst_InstrD", InstrD, 32'h13);
        chk("rst_ValidE", 32'(ValidE), 32'h0);
        chk("rst_StallCnt", 32'(StallCnt), 32'h0);
        quiet(); tick(); chk("rel_PCF_4", PCF, 32'h4);
        quiet(); tick(); chk("rel_PCF_8", PCF, 32'h8);
        quiet(); tick();
        quiet(); tick(); chk("pre_lu_PCF", PCF, 32'h10);
        held = last_fetched;
        // Load-use bubble.
        quiet(); StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1; tick();
        chk("lu_PCF", PCF, 32'h10);
        chk("lu_InstrD", InstrD, held);
        chk("lu_ValidE", 32'(ValidE), 32'h0);
        chk("lu_StallCnt", 32'(StallCnt), 32'h1);
        chk("lu_FlushCnt", 32'(FlushCnt), 32'h1);
        // Taken branch.
        quiet(); PCSrcE = 2'b01; PCTargetE = 32'h200; FlushD = 1'b1; FlushE = 1'b1; tick();
        chk("br_PCF", PCF, 32'h200);
        chk("br_ValidD", 32'(ValidD), 32'h0);
        chk("br_InstrD", InstrD, 32'h13);
        chk("br_ValidE", 32'(ValidE), 32'h0);
        chk("br_FlushCnt", 32'(FlushCnt), 32'h2);
        // Redirect against a simultaneous stall.
        quiet(); StallF = 1'b1; StallD = 1'b1; PCSrcE = 2'b10; ALUResultE = 32'h300; FlushD = 1'b1; tick();
        chk("cf_PCF", PCF, 32'h300);
        chk("cf_ValidD", 32'(ValidD), 32'h0);
        // Decode fields pass through to Execute.
        quiet(); RdD = 5'd5; RegWriteD = 1'b1; ImmExtD = 32'hABCD; tick();
        chk("pt_RdE", 32'(RdE), 32'h5);
        chk("pt_RegWriteE", 32'(RegWriteE), 32'h1);
        chk("pt_ImmExtE", ImmExtE, 32'hABCD);
        // Reserved select behaves as the branch target.
        quiet(); PCSrcE = 2'b11; PCTargetE = 32'h440; ALUResultE = 32'h880; tick();
        chk("rsvd_PCF", PCF, 32'h440);
        // PC wrap.
        quiet(); PCSrcE = 2'b01; PCTargetE = 32'hFFFF_FFFC; tick();
        quiet(); tick();
        chk("wrap_PCF", PCF, 32'h0);
        // Stall counter saturation.
        quiet(); StallD = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        chk("sat_StallCnt", 32'(StallCnt), 32'hFFFF);
        // Reset in the middle of a stall discards everything.
        rst = 1'b1; tick();
        chk("rms_StallCnt", 32'(StallCnt), 32'h0);
        chk("rms_PCF", PCF, RST_PC);
        chk("rms_ValidD", 32'(ValidD), 32'h0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            rst    = ($urandom_range(0, 63) == 0);
            StallF = ($urandom_range(0, 3) == 0);
            StallD = ($urandom_range(0, 3) == 0);
            FlushD = ($urandom_range(0, 4) == 0);
            FlushE = ($urandom_range(0, 4) == 0);
            PCSrcE = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            tick();
        end
        quiet();
        repeat (3) @(posedge clk);
        #3;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
